// File: rtl/banco_nos_ativos_pkg.sv
// Shared parameters for the active-node bank and its neighbours.
// Holds the default sizes and the search FSM encoding.
package banco_nos_ativos_pkg;

  localparam int NA_DEF = 8;
  localparam int AW_DEF = 5;
  localparam int DW_DEF = 5;
  localparam int CW_DEF = 4;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    MINIMO = 2'd1,
    APROVA = 2'd2,
    FIM    = 2'd3
  } estado_t;

endpackage

// File: rtl/banco_nos_ativos_if.sv
// Bus between the manager and the active-node bank.
// The master side drives updates and searches; the slave side is the bank.
interface banco_nos_ativos_if
  import banco_nos_ativos_pkg::*;
#(
  parameter int NUM_NA          = NA_DEF,
  parameter int ADDR_WIDTH      = AW_DEF,
  parameter int DISTANCIA_WIDTH = DW_DEF,
  parameter int CUSTO_WIDTH     = CW_DEF
);

  logic                              ga_desativar_in;
  logic                              ga_atualizar_in;
  logic [ADDR_WIDTH-1:0]             ga_anterior_in;
  logic [NUM_NA-1:0]                 ga_habilitar_in;
  logic [ADDR_WIDTH*NUM_NA-1:0]      ga_endereco_in;
  logic [CUSTO_WIDTH*NUM_NA-1:0]     ga_menor_vizinho_in;
  logic [DISTANCIA_WIDTH*NUM_NA-1:0] ga_distancia_in;
  logic                              busca_in;
  logic [ADDR_WIDTH*NUM_NA-1:0]      na_endereco_out;
  logic [NUM_NA-1:0]                 na_ativo_out;
  logic [NUM_NA-1:0]                 aprovado_out;
  logic [DISTANCIA_WIDTH:0]          limite_out;
  logic                              busca_done_out;
  logic                              vazio_out;
  logic                              ocupado_out;

  modport master (
    output ga_desativar_in, ga_atualizar_in,
    output ga_anterior_in, ga_habilitar_in,
    output ga_endereco_in, ga_menor_vizinho_in,
    output ga_distancia_in, busca_in,
    input  na_endereco_out, na_ativo_out,
    input  aprovado_out, limite_out,
    input  busca_done_out, vazio_out, ocupado_out
  );

  modport slave (
    input  ga_desativar_in, ga_atualizar_in,
    input  ga_anterior_in, ga_habilitar_in,
    input  ga_endereco_in, ga_menor_vizinho_in,
    input  ga_distancia_in, busca_in,
    output na_endereco_out, na_ativo_out,
    output aprovado_out, limite_out,
    output busca_done_out, vazio_out, ocupado_out
  );

endinterface

// File: rtl/banco_nos_ativos_entrada_no_ativo.sv
// One entry of the active-node bank.
// A write on the same edge as a matching deactivate takes priority.
module entrada_no_ativo #(
  parameter int ADDR_WIDTH      = 5,
  parameter int DISTANCIA_WIDTH = 5,
  parameter int CUSTO_WIDTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       desativar,
  input  logic                       atualizar,
  input  logic                       habilitar,
  input  logic [ADDR_WIDTH-1:0]      anterior,
  input  logic [ADDR_WIDTH-1:0]      novo_endereco,
  input  logic [DISTANCIA_WIDTH-1:0] nova_distancia,
  input  logic [CUSTO_WIDTH-1:0]     novo_custo,
  output logic                       ativo,
  output logic [ADDR_WIDTH-1:0]      endereco,
  output logic [DISTANCIA_WIDTH-1:0] distancia,
  output logic [CUSTO_WIDTH-1:0]     menor_vizinho
);

  always_ff @(posedge clk) begin
    if (rst) begin
      ativo         <= 1'b0;
      endereco      <= '0;
      distancia     <= '0;
      menor_vizinho <= '0;
    end else if (atualizar && habilitar) begin
      ativo         <= 1'b1;
      endereco      <= novo_endereco;
      distancia     <= nova_distancia;
      menor_vizinho <= novo_custo;
    end else if (desativar && ativo && endereco == anterior) begin
      ativo <= 1'b0;
    end
  end

endmodule

// File: rtl/banco_nos_ativos.sv
// Active-node bank: NUM_NA entries plus a serial minimum scan
// that approves every active node within the smallest bound.
module banco_nos_ativos
  import banco_nos_ativos_pkg::*;
#(
  parameter int NUM_NA          = NA_DEF,
  parameter int ADDR_WIDTH      = AW_DEF,
  parameter int DISTANCIA_WIDTH = DW_DEF,
  parameter int CUSTO_WIDTH     = CW_DEF
) (
  input logic               clk,
  input logic               rst,
  banco_nos_ativos_if.slave bus
);

  localparam int IW = (NUM_NA > 1) ? $clog2(NUM_NA) : 1;
  localparam int LW = DISTANCIA_WIDTH + 1;

  logic [NUM_NA-1:0]          ativo;
  logic [ADDR_WIDTH-1:0]      endereco [NUM_NA];
  logic [DISTANCIA_WIDTH-1:0] distancia [NUM_NA];
  logic [CUSTO_WIDTH-1:0]     custo [NUM_NA];

  for (genvar i = 0; i < NUM_NA; i++) begin : g_na
    entrada_no_ativo #(
      .ADDR_WIDTH      (ADDR_WIDTH),
      .DISTANCIA_WIDTH (DISTANCIA_WIDTH),
      .CUSTO_WIDTH     (CUSTO_WIDTH)
    ) u_na (
      .clk            (clk),
      .rst            (rst),
      .desativar      (bus.ga_desativar_in),
      .atualizar      (bus.ga_atualizar_in),
      .habilitar      (bus.ga_habilitar_in[i]),
      .anterior       (bus.ga_anterior_in),
      .novo_endereco  (bus.ga_endereco_in[ADDR_WIDTH*i +: ADDR_WIDTH]),
      .nova_distancia (bus.ga_distancia_in[DISTANCIA_WIDTH*i +: DISTANCIA_WIDTH]),
      .novo_custo     (bus.ga_menor_vizinho_in[CUSTO_WIDTH*i +: CUSTO_WIDTH]),
      .ativo          (ativo[i]),
      .endereco       (endereco[i]),
      .distancia      (distancia[i]),
      .menor_vizinho  (custo[i])
    );
    assign bus.na_endereco_out[ADDR_WIDTH*i +: ADDR_WIDTH] = endereco[i];
  end

  estado_t           estado, prox;
  logic [IW-1:0]     idx, idx_nx;
  logic [LW-1:0]     limite, limite_nx;
  logic [NUM_NA-1:0] aprovado, aprovado_nx;
  logic [LW-1:0]     soma;
  logic              limpa;
  logic              done;

  assign limpa = bus.ga_atualizar_in || bus.ga_desativar_in;
  assign soma  = {1'b0, distancia[idx]} + LW'(custo[idx]);

  always_ff @(posedge clk) begin
    if (rst) begin
      estado   <= OCIOSO;
      idx      <= '0;
      limite   <= '1;
      aprovado <= '0;
    end else begin
      estado   <= prox;
      idx      <= idx_nx;
      limite   <= limite_nx;
      aprovado <= aprovado_nx;
    end
  end

  // Any table change during the scan restarts it so the result
  // always reflects one consistent snapshot of the table.
  always_comb begin
    prox        = estado;
    idx_nx      = idx;
    limite_nx   = limite;
    aprovado_nx = aprovado;
    done        = 1'b0;
    unique case (estado)
      OCIOSO: begin
        if (bus.busca_in) begin
          prox      = MINIMO;
          idx_nx    = '0;
          limite_nx = '1;
        end
      end
      MINIMO: begin
        if (limpa) begin
          idx_nx    = '0;
          limite_nx = '1;
        end else begin
          if (ativo[idx] && soma < limite) limite_nx = soma;
          if (idx == IW'(NUM_NA - 1)) prox = APROVA;
          else idx_nx = idx + 1'b1;
        end
      end
      APROVA: begin
        if (limpa) begin
          prox      = MINIMO;
          idx_nx    = '0;
          limite_nx = '1;
        end else begin
          for (int i = 0; i < NUM_NA; i++)
            aprovado_nx[i] = ativo[i] && ({1'b0, distancia[i]} <= limite);
          prox = FIM;
        end
      end
      FIM: begin
        done = 1'b1;
        prox = OCIOSO;
      end
      default: prox = OCIOSO;
    endcase
  end

  assign bus.na_ativo_out   = ativo;
  assign bus.aprovado_out   = aprovado;
  assign bus.limite_out     = limite;
  assign bus.busca_done_out = done;
  assign bus.vazio_out      = ~|ativo;
  assign bus.ocupado_out    = (estado != OCIOSO) || limpa;

endmodule

// File: doc/banco_nos_ativos.md
BANCO_NOS_ATIVOS -- requirements
Module: banco_nos_ativos

Interface
REQ-001 Parameters: NUM_NA=8 (entry count); ADDR_WIDTH=5 (node address); DISTANCIA_WIDTH=5 (accumulated distance); CUSTO_WIDTH=4 (smallest outgoing edge cost).
REQ-002 Ports, clock and reset first:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  reset; synchronous, active-high.
- ga_desativar_in  in  1  deactivate the entry whose address equals ga_anterior_in.
- ga_atualizar_in  in  1  load every entry flagged in ga_habilitar_in.
- ga_anterior_in  in  ADDR_WIDTH  address to deactivate.
- ga_habilitar_in  in  NUM_NA  per-entry write enable.
- ga_endereco_in  in  ADDR_WIDTH*NUM_NA  flattened addresses; entry i at [ADDR_WIDTH*i +: ADDR_WIDTH].
- ga_menor_vizinho_in  in  CUSTO_WIDTH*NUM_NA  flattened costs.
- ga_distancia_in  in  DISTANCIA_WIDTH*NUM_NA  flattened distances.
- busca_in  in  1  start an approval search.
- na_endereco_out  out  ADDR_WIDTH*NUM_NA  stored addresses.
- na_ativo_out  out  NUM_NA  per-entry active flag.
- aprovado_out  out  NUM_NA  approved-entry mask from the last search.
- limite_out  out  DISTANCIA_WIDTH+1  minimum of (distancia+menor_vizinho) over active entries.
- busca_done_out  out  1  one-cycle pulse when the search completes.
- vazio_out  out  1  no entry is active.
- ocupado_out  out  1  a search is in progress.

Function
REQ-003 Storage: each entry holds ativo, endereco, distancia and menor_vizinho registers.
REQ-004 Write: when ga_atualizar_in=1 and ga_habilitar_in[i]=1, entry i loads its slices and sets ativo=1 on the next edge.
REQ-005 Deactivate: when ga_desativar_in=1, every entry with ativo=1 and endereco==ga_anterior_in clears ativo on the next edge; the entry's data fields are unchanged.
REQ-006 Simultaneous deactivate and write on the same entry: the write wins, so ativo=1 and the new data are stored.
REQ-007 na_endereco_out and na_ativo_out are taken directly from the registers, with no extra latency.
REQ-008 vazio_out = ~|na_ativo_out, combinational.
REQ-009 Search FSM has states OCIOSO, MINIMO, APROVA and FIM.
REQ-010 OCIOSO: busca_in=1 sets idx=0, sets limite to all-ones, and moves to MINIMO. busca_in is ignored in every other state.
REQ-011 MINIMO: scans one entry per cycle, idx 0..NUM_NA-1. For an active entry, soma = {1'b0,distancia} + menor_vizinho, at width DISTANCIA_WIDTH+1 with no overflow; if soma < limite, then limite <= soma. Moves to APROVA after idx=NUM_NA-1.
REQ-012 APROVA: aprovado[i] <= ativo[i] && ({1'b0,distancia[i]} <= limite) for all i in parallel; then moves to FIM.
REQ-013 FIM: busca_done_out=1 for exactly this cycle; then returns to OCIOSO.
REQ-014 Latency: with busca_in high at edge t, busca_done_out is high during cycle t+NUM_NA+2.
REQ-015 aprovado_out and limite_out are registered, update only in APROVA/MINIMO, and hold until the next search.
REQ-016 A write or deactivate that arrives while in MINIMO or APROVA aborts the scan: idx=0, limite=all-ones, state=MINIMO. The pending search is completed, never dropped.
REQ-017 Empty table at APROVA: aprovado_out=0, limite_out stays all-ones, and busca_done_out still pulses.
REQ-018 ocupado_out = (state != OCIOSO) || ga_atualizar_in || ga_desativar_in.

Reset
REQ-019 With rst=1 at a clock edge: all ativo=0; all endereco/distancia/menor_vizinho=0; aprovado_out=0; limite_out=all-ones; busca_done_out=0; state=OCIOSO; idx=0.
REQ-020 A reset asserted mid-search abandons the search with no busca_done_out pulse.

Structure
REQ-021 Default parameter values and the FSM state encodings live in the shared project parameter header, alongside those used by the gerenciador/LVV blocks.
REQ-022 One sub-module, entrada_no_ativo, holds a single entry and its write/deactivate logic. The top level instantiates NUM_NA copies and contains the scan FSM.

Verification
REQ-023 Reset, then write entry 0 (addr 3, dist 0, custo 2) with habilitar=8'h01 -> next cycle na_ativo_out=8'h01 and addr slice 0 = 3.
REQ-024 Entries 0:(d2,c3), 1:(d4,c1), 2:(d6,c2) active; pulse busca_in -> limite_out=5, aprovado_out=8'h03, busca_done_out high exactly NUM_NA+2 cycles later.
REQ-025 Same cycle ga_desativar_in with anterior=3 and ga_atualizar_in on entry 0 with addr 3 -> entry 0 remains active holding the new data.
REQ-026 ga_atualizar_in at scan cycle 4 -> scan restarts, done delayed 5 cycles, and the result reflects the new data.
REQ-027 Empty table plus busca_in -> done pulses, aprovado_out=0, limite_out=6'h3F, vazio_out=1.
REQ-028 Entry with d31, c15 -> soma=46 with no wrap, so limite_out=46 and the entry is approved.
